// File: rtl/bsg_mesh_traffic_gen.sv
// Mesh traffic generator/checker: sends sequenced packets to a sweep, LFSR-random or fixed
// destination, and checks every received packet for destination, source range and seq order.
module bsg_mesh_traffic_gen #(
  parameter int num_x_p         = 4,
  parameter int num_y_p         = 4,
  parameter int x_cord_width_p  = (num_x_p > 1) ? $clog2(num_x_p) : 1,
  parameter int y_cord_width_p  = (num_y_p > 1) ? $clog2(num_y_p) : 1,
  parameter int seq_width_p     = 16,
  parameter int total_packets_p = 256,
  localparam int width_lp = seq_width_p + 2*(x_cord_width_p + y_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      en_i,
  input  logic [1:0]                mode_i,
  input  logic [x_cord_width_p-1:0] fixed_x_i,
  input  logic [y_cord_width_p-1:0] fixed_y_i,
  output logic [width_lp-1:0]       data_o,
  output logic                      v_o,
  input  logic                      ready_and_i,
  input  logic [width_lp-1:0]       data_i,
  input  logic                      v_i,
  output logic                      yumi_o,
  output logic [31:0]               sent_count_o,
  output logic [31:0]               recv_count_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [x_cord_width_p-1:0] err_x_o,
  output logic [y_cord_width_p-1:0] err_y_o
);

  localparam int tiles_lp = num_x_p * num_y_p;
  localparam int idx_w_lp = (tiles_lp > 1) ? $clog2(tiles_lp) : 1;
  localparam logic [31:0] num_x_lp = 32'(num_x_p);
  localparam logic [31:0] num_y_lp = 32'(num_y_p);
  localparam logic [seq_width_p-1:0]    last_seq_lp = seq_width_p'(total_packets_p - 1);
  localparam logic [x_cord_width_p-1:0] max_x_lp    = x_cord_width_p'(num_x_p - 1);
  localparam logic [y_cord_width_p-1:0] max_y_lp    = y_cord_width_p'(num_y_p - 1);
  localparam logic [1:0] mode_sweep_lp = 2'd0;
  localparam logic [1:0] mode_rand_lp  = 2'd1;
  localparam logic [1:0] mode_fixed_lp = 2'd2;
  localparam logic [1:0] mode_rsvd_lp  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_e                      state_q, state_d;
  logic [1:0]                  mode_q, mode_d;
  logic                        mode_err;
  logic [seq_width_p-1:0]      seq_q;
  logic [x_cord_width_p-1:0]   sweep_x_q, dest_x;
  logic [y_cord_width_p-1:0]   sweep_y_q, dest_y;
  logic [15:0]                 lfsr_q, lfsr_seed;
  logic [31:0]                 sent_q, recv_q;
  logic                        send;

  logic [x_cord_width_p-1:0]   chk_dest_x, chk_src_x;
  logic [y_cord_width_p-1:0]   chk_dest_y, chk_src_y;
  logic [seq_width_p-1:0]      chk_seq;
  logic [idx_w_lp-1:0]         src_idx;
  logic                        src_ok, seq_bad, pkt_bad;
  logic [tiles_lp-1:0]         seen_q;
  logic [seq_width_p-1:0]      last_seq_q [tiles_lp];
  logic                        err_q;
  logic [x_cord_width_p-1:0]   err_x_q;
  logic [y_cord_width_p-1:0]   err_y_q;

  assign v_o       = (state_q == S_SEND) && en_i && !reset_i;
  assign send      = v_o && ready_and_i;
  assign yumi_o    = v_i && !reset_i;
  assign done_o    = (state_q == S_DONE) && !reset_i;
  assign err_o     = err_q && !reset_i;
  assign err_x_o   = err_x_q;
  assign err_y_o   = err_y_q;
  assign sent_count_o = sent_q;
  assign recv_count_o = recv_q;
  assign lfsr_seed = 16'({my_y_i, my_x_i}) | 16'd1;

  always_comb begin
    dest_x = sweep_x_q;
    dest_y = sweep_y_q;
    case (mode_q)
      mode_rand_lp: begin
        dest_x = lfsr_q[x_cord_width_p-1:0];
        dest_y = lfsr_q[x_cord_width_p +: y_cord_width_p];
      end
      mode_fixed_lp: begin
        dest_x = fixed_x_i;
        dest_y = fixed_y_i;
      end
      default: ;
    endcase
  end

  assign data_o = {seq_q, my_y_i, my_x_i, dest_y, dest_x};

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    mode_err = 1'b0;
    case (state_q)
      S_IDLE: if (en_i) begin
        mode_d = mode_i;
        if (mode_i == mode_rsvd_lp) begin
          state_d  = S_DONE;
          mode_err = 1'b1;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: if (send && (seq_q == last_seq_lp)) state_d = S_DONE;
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      mode_q  <= mode_sweep_lp;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seq_q     <= '0;
      sweep_x_q <= '0;
      sweep_y_q <= '0;
      lfsr_q    <= lfsr_seed;
      sent_q    <= '0;
    end else if (send) begin
      seq_q  <= seq_q + seq_width_p'(1);
      lfsr_q <= lfsr_step(lfsr_q);
      sent_q <= sat_inc(sent_q);
      if (mode_q == mode_sweep_lp) begin
        if (sweep_x_q == max_x_lp) begin
          sweep_x_q <= '0;
          sweep_y_q <= (sweep_y_q == max_y_lp) ? '0 : sweep_y_q + y_cord_width_p'(1);
        end else begin
          sweep_x_q <= sweep_x_q + x_cord_width_p'(1);
        end
      end
    end
  end

  assign chk_dest_x = data_i[x_cord_width_p-1:0];
  assign chk_dest_y = data_i[x_cord_width_p +: y_cord_width_p];
  assign chk_src_x  = data_i[x_cord_width_p + y_cord_width_p +: x_cord_width_p];
  assign chk_src_y  = data_i[2*x_cord_width_p + y_cord_width_p +: y_cord_width_p];
  assign chk_seq    = data_i[width_lp-1 -: seq_width_p];

  // Per-source history is only indexed when the source lies inside the mesh
  assign src_ok  = (32'(chk_src_x) < num_x_lp) && (32'(chk_src_y) < num_y_lp);
  assign src_idx = idx_w_lp'(32'(chk_src_y) * num_x_lp + 32'(chk_src_x));
  assign seq_bad = src_ok && seen_q[src_idx] && (chk_seq <= last_seq_q[src_idx]);
  assign pkt_bad = (chk_dest_x != my_x_i) || (chk_dest_y != my_y_i) || !src_ok || seq_bad;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      recv_q  <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      err_x_q <= '0;
      err_y_q <= '0;
    end else begin
      if (yumi_o) begin
        recv_q <= sat_inc(recv_q);
        if (src_ok) seen_q[src_idx] <= 1'b1;
      end
      if (!err_q) begin
        if (yumi_o && pkt_bad) begin
          err_q   <= 1'b1;
          err_x_q <= chk_src_x;
          err_y_q <= chk_src_y;
        end else if (mode_err) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (yumi_o && src_ok && !seq_bad) last_seq_q[src_idx] <= chk_seq;
  end

endmodule

// File: doc/bsg_mesh_traffic_gen.md
BSG_MESH_TRAFFIC_GEN -- requirements
Module: bsg_mesh_traffic_gen

Interface
REQ-001 The module SHALL have parameter num_x_p, default 4: mesh columns, >=1.
REQ-002 The module SHALL have parameter num_y_p, default 4: mesh rows, >=1.
REQ-003 The module SHALL have parameter x_cord_width_p, default `BSG_SAFE_CLOG2(num_x_p): x coordinate width.
REQ-004 The module SHALL have parameter y_cord_width_p, default `BSG_SAFE_CLOG2(num_y_p): y coordinate width.
REQ-005 The module SHALL have parameter seq_width_p, default 16: sequence-number width.
REQ-006 The module SHALL have parameter total_packets_p, default 256: packets sent per run, 1..2^seq_width_p.
REQ-007 The module SHALL have localparam width_lp = seq_width_p + 2*(x_cord_width_p + y_cord_width_p): packet width.
REQ-008 The module SHALL have ports clk_i (input, 1, clock) and reset_i (input, 1), one clock, reset synchronous and active-high.
REQ-009 The module SHALL have inputs my_x_i (x_cord_width_p) and my_y_i (y_cord_width_p): own tile coordinates, static after reset.
REQ-010 The module SHALL have inputs en_i (1): start/continue generation, and mode_i (2): 0 sweep, 1 random, 2 fixed destination, 3 reserved.
REQ-011 The module SHALL have inputs fixed_x_i (x_cord_width_p) and fixed_y_i (y_cord_width_p): destination in mode 2.
REQ-012 The module SHALL have outputs data_o (width_lp) and v_o (1), and input ready_and_i (1): send port, valid/ready.
REQ-013 The module SHALL have inputs data_i (width_lp) and v_i (1), and output yumi_o (1): receive port, valid/yumi.
REQ-014 The module SHALL have outputs sent_count_o and recv_count_o (32 each): counters.
REQ-015 The module SHALL have outputs done_o (1), err_o (1, sticky), err_x_o (x_cord_width_p) and err_y_o (y_cord_width_p): source of the first error.

Function
REQ-016 Packet layout SHALL be {seq, src_y, src_x, dest_y, dest_x}, dest_x in the LSBs.
REQ-017 The generator SHALL have states IDLE, SEND and DONE; IDLE->SEND when en_i=1; SEND->DONE on the handshake of packet total_packets_p; DONE holds until reset.
REQ-018 In SEND, v_o SHALL equal en_i; deasserting en_i pauses generation without changing state or counters.
REQ-019 data_o SHALL be held stable while v_o=1 and ready_and_i=0.
REQ-020 A send SHALL occur when v_o and ready_and_i are both 1; each send increments seq and sent_count_o by 1; the first packet after reset carries seq=0.
REQ-021 In mode 0, the destination SHALL start at (0,0); x increments per send; at num_x_p-1, x wraps to 0 and y increments; at (num_x_p-1, num_y_p-1), it wraps to (0,0); own tile is included.
REQ-022 In mode 1, the destination SHALL be taken from the low bits of a 16-bit maximal LFSR (x4 x low, next bits y), seeded at reset with {my_y_i, my_x_i} OR 1 and advanced only on a send; mode 1 requires power-of-2 num_x_p and num_y_p.
REQ-023 In mode 2, the destination SHALL be fixed_x_i/fixed_y_i.
REQ-024 mode_i SHALL be sampled only in IDLE->SEND; mode 3 sets err_o and moves to DONE without sending.
REQ-025 yumi_o SHALL equal v_i while reset_i=0, so every arriving packet is consumed in the same cycle.
REQ-026 On each consumed packet, recv_count_o SHALL increment and the checker SHALL flag an error when dest != (my_x_i, my_y_i), src_x >= num_x_p, src_y >= num_y_p, or seq <= the last seq recorded for that source.
REQ-027 The checker SHALL keep a last-seq register plus a seen bit per source (num_x_p*num_y_p entries); the first packet from a source is accepted for any seq.
REQ-028 On the first error, err_o SHALL be set and err_x_o/err_y_o latch src_x/src_y; later errors change nothing; all three hold until reset.
REQ-029 done_o SHALL be 1 exactly when in DONE.
REQ-030 A simultaneous send and receive in the same cycle SHALL both update independently.
REQ-031 The 32-bit counters SHALL saturate at 2^32-1.

Reset
REQ-032 While reset_i=1, v_o, yumi_o, done_o and err_o SHALL be 0; counters, seq, destination and err_x_o/err_y_o reset to 0, seen bits clear, LFSR reseeds, state goes to IDLE.
REQ-033 Reset asserted mid-packet SHALL drop v_o the next cycle; the in-flight packet is abandoned with no count update.
REQ-034 Generation SHALL resume only after reset_i falls and en_i=1.

Verification
REQ-035 The bench SHALL cover sweep mode: 2x2, total_packets_p=8, my=(1,0), ready_and_i=1 -> dests (0,0),(1,0),(0,1),(1,1),(0,0)..., seq 0..7, done_o high after 8th send.
REQ-036 The bench SHALL cover backpressure: ready_and_i toggles every cycle -> data_o stable while stalled, sent_count_o=8 at done, no duplicate seq.
REQ-037 The bench SHALL cover the checker: inject src(1,1) seq 5 then seq 5 to tile (0,0) -> err_o=1, err_x_o=1, err_y_o=1, recv_count_o=2.
REQ-038 The bench SHALL cover wrong destination: packet dest(1,0) into tile (0,0) -> err_o=1 next cycle, yumi_o=1 same cycle.
REQ-039 The bench SHALL cover full 4x4 mesh all-to-all in modes 0 and 1 with 16 generators, total_packets_p=256 -> all done_o, sum of recv_count_o=4096, no err_o.
REQ-040 The bench SHALL cover reset mid-SEND after 3 sends -> counters 0, v_o=0, restart emits seq 0 to (0,0) in mode 0.
